mp_alu: RTL and testbench
=========================

Name: mp_alu

Overview:
Multi-cycle, slice-serial ALU. Processes WIDTH-bit operands SLICE bits per clock, chaining carry and flag state across slices. It is the wide-word successor to the single-cycle combinational ALU: same operation set and S/Z/C/V flags, parametrised operand width, and a valid/ready request/response handshake. It sits between the register file and the writeback stage in multi-precision configurations where a full-width combinational adder is too large or too slow.

Parameters:
WIDTH, 16, operand and result width in bits. Must satisfy WIDTH % SLICE == 0 and WIDTH >= 2.
SLICE, 4, bits processed per cycle. NSLICE = WIDTH/SLICE. SLICE == WIDTH gives a 1-slice configuration.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request.
req_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 RL, 7 RR.
req_use_c  in  1  include carry-in cin (ADD/SUB/RL/RR).
req_arith  in  1  RR only: fill MSB with the sign bit when req_use_c=0.
req_cin  in  1  incoming carry flag.
req_a  in  WIDTH  operand 1.
req_b  in  WIDTH  operand 2.
rsp_valid  out  1  result and flags valid.
rsp_ready  in  1  consumer accepts the response.
rsp_dout  out  WIDTH  result.
rsp_s, rsp_z, rsp_c, rsp_v  out  1 each  sign, zero, carry and overflow flags.

Behaviour:
- Reset is synchronous and active-high on clk. Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_dout=0, all flags 0. Reset in any state aborts the operation in flight, with no response.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: req_ready=1. Acceptance is req_valid & req_ready at an edge. On acceptance, the block captures op, mode bits, cin, a and b, clears the slice counter and goes to RUN. Inputs may change after acceptance.
  - RUN: req_ready=0. Exactly one SLICE-bit slice per cycle. After NSLICE RUN edges, the block registers the result and goes to DONE.
  - DONE: rsp_valid=1. Outputs stay stable until rsp_valid & rsp_ready. At that edge the block goes to IDLE and rsp_valid drops. There is no same-cycle turnaround: req_ready returns the cycle after the handshake. Requests offered while not IDLE are ignored.
- Latency: rsp_valid is first high NSLICE+1 cycles after the acceptance edge. In IDLE and RUN, the rsp_* outputs hold their last values.
- Arithmetic, modulo 2^WIDTH:
  - ADD: a + b + (use_c & cin).
  - SUB: a + ~b + (use_c ? ~cin : 1), i.e. borrow-in = use_c & cin. C=1 means no borrow.
  - Carry is chained between slices. C = carry out of bit WIDTH-1.
  - V = (a[MSB] ^ r[MSB]) & (b'[MSB] ^ r[MSB]), where b' = b for ADD and ~b for SUB.
- Logic ops: AND/OR/XOR on a,b; NOT = ~b. C=0, V=0.
- RL: r = {a[WIDTH-2:0], use_c ? cin : 0}, C = a[WIDTH-1], V=0.
- RR: r = {fill, a[WIDTH-1:1]}, C = a[0], V=0. fill = cin if use_c, else a[WIDTH-1] if arith, else 0.
- Flags for all ops: S = r[WIDTH-1]. Z = (r == 0), accumulated across slices (AND of per-slice zero).
- Slice processing order is internal and not observable. Only the final result, flags and latency are specified.

Test Plan:
- WIDTH=16, SLICE=4: ADD a=0x7FFF b=0x0001 use_c=0 -> dout=0x8000, S=1 Z=0 C=0 V=1; rsp_valid first high 5 cycles after acceptance.
- SUB a=0x0005 b=0x0005 use_c=0 -> 0x0000, Z=1 C=1 V=0. SUB a=0x0000 b=0x0001 -> 0xFFFF, S=1 C=0.
- ADD a=0xFFFF b=0x0000 use_c=1 cin=1 -> 0x0000, Z=1 C=1 (carry ripples through all 4 slices). RL a=0x8000 use_c=1 cin=1 -> 0x0001, C=1.
- RR a=0x8001: arith=1 -> 0xC000 C=1 S=1; arith=0 -> 0x4000; use_c=1 cin=0 -> 0x4000.
- Backpressure: rsp_ready low 3 cycles after rsp_valid -> outputs stable, req_ready=0, a concurrent req_valid is ignored. After the handshake, req_ready=1 the next cycle and a back-to-back request completes correctly.
- rst asserted 2 cycles into RUN -> next cycle req_ready=1, rsp_valid=0, outputs 0, and no response is ever produced for the aborted request. Also repeat the ADD case with SLICE=16 -> latency 2.

Source files
------------

// File: rtl/mp_alu.sv
// Slice-serial ALU: walks WIDTH-bit operands SLICE bits per clock, chaining
// carry and zero state across slices, behind a valid/ready request/response pair.
module mp_alu #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_use_c,
  input  logic             req_arith,
  input  logic             req_cin,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_dout,
  output logic             rsp_s,
  output logic             rsp_z,
  output logic             rsp_c,
  output logic             rsp_v
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = $clog2(NSLICE + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_NOT = 3'd5;
  localparam logic [2:0] OP_RL  = 3'd6;
  localparam logic [2:0] OP_RR  = 3'd7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             useC_q, useC_d;
  logic             arith_q, arith_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             s_q, s_d, z_q, z_d, c_q, c_d, v_q, v_d;

  logic [WIDTH-1:0] rlVec, rrVec;
  logic [SLICE-1:0] aSl, bSl, rlSl, rrSl, bEff, rSl;
  logic [SLICE:0]   sum;
  logic             isSub, isArith;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      useC_q  <= 1'b0;
      arith_q <= 1'b0;
      cin_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      dout_q  <= '0;
      s_q     <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      useC_q  <= useC_d;
      arith_q <= arith_d;
      cin_q   <= cin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      dout_q  <= dout_d;
      s_q     <= s_d;
      z_q     <= z_d;
      c_q     <= c_d;
      v_q     <= v_d;
    end
  end

  // Rotates are pure rewiring of the captured operand, so they are sliced like any other op.
  always_comb begin
    rlVec   = {a_q[WIDTH-2:0], useC_q & cin_q};
    rrVec   = {(useC_q ? cin_q : (arith_q & a_q[WIDTH-1])), a_q[WIDTH-1:1]};
    isSub   = (op_q == OP_SUB);
    isArith = (op_q == OP_ADD) || isSub;
    aSl  = '0;
    bSl  = '0;
    rlSl = '0;
    rrSl = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt_q == CW'(i)) begin
        aSl  = a_q[i*SLICE +: SLICE];
        bSl  = b_q[i*SLICE +: SLICE];
        rlSl = rlVec[i*SLICE +: SLICE];
        rrSl = rrVec[i*SLICE +: SLICE];
      end
    end
    bEff = isSub ? ~bSl : bSl;
    sum  = {1'b0, aSl} + {1'b0, bEff} + {{SLICE{1'b0}}, carry_q};
    case (op_q)
      OP_ADD, OP_SUB: rSl = sum[SLICE-1:0];
      OP_AND:         rSl = aSl & bSl;
      OP_OR:          rSl = aSl | bSl;
      OP_XOR:         rSl = aSl ^ bSl;
      OP_NOT:         rSl = ~bSl;
      OP_RL:          rSl = rlSl;
      default:        rSl = rrSl;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    useC_d  = useC_q;
    arith_d = arith_q;
    cin_d   = cin_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    zero_d  = zero_q;
    dout_d  = dout_q;
    s_d     = s_q;
    z_d     = z_q;
    c_d     = c_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          useC_d  = req_use_c;
          arith_d = req_arith;
          cin_d   = req_cin;
          a_d     = req_a;
          b_d     = req_b;
          cnt_d   = '0;
          zero_d  = 1'b1;
          // SUB seeds the chain with the inverted borrow so ~b + 1 forms the two's complement.
          carry_d = (req_op == OP_SUB) ? (req_use_c ? ~req_cin : 1'b1)
                                       : (req_use_c & req_cin);
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(NSLICE)) begin
          dout_d  = work_q;
          s_d     = work_q[WIDTH-1];
          z_d     = zero_q;
          c_d     = 1'b0;
          v_d     = 1'b0;
          if (isArith) begin
            c_d = carry_q;
            v_d = (a_q[WIDTH-1] ^ work_q[WIDTH-1]) &
                  ((b_q[WIDTH-1] ^ isSub) ^ work_q[WIDTH-1]);
          end else if (op_q == OP_RL) begin
            c_d = a_q[WIDTH-1];
          end else if (op_q == OP_RR) begin
            c_d = a_q[0];
          end
          state_d = DONE;
        end else begin
          for (int i = 0; i < NSLICE; i++) begin
            if (cnt_q == CW'(i)) work_d[i*SLICE +: SLICE] = rSl;
          end
          carry_d = sum[SLICE];
          zero_d  = zero_q & (rSl == '0);
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_dout  = dout_q;
  assign rsp_s     = s_q;
  assign rsp_z     = z_q;
  assign rsp_c     = c_q;
  assign rsp_v     = v_q;

endmodule

// File: tb/tb_mp_alu.sv
// Directed bench for mp_alu: a table of hand-computed vectors on the 4-slice build,
// plus backpressure, mid-run reset and single-slice latency sequences.
module tb_mp_alu;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, NOT_ = 3'd5, RL = 3'd6, RR = 3'd7;

  typedef struct packed {
    logic [2:0]  op;
    logic        useC;
    logic        arith;
    logic        cin;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] dout;
    logic [3:0]  flags;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_valid2 = 1'b0;
  logic        rsp_ready = 1'b0, rsp_ready2 = 1'b0;
  logic [2:0]  req_op = '0;
  logic        req_use_c = 1'b0, req_arith = 1'b0, req_cin = 1'b0;
  logic [15:0] req_a = '0, req_b = '0;
  logic        req_ready, rsp_valid, rsp_s, rsp_z, rsp_c, rsp_v;
  logic [15:0] rsp_dout;
  logic        req_ready2, rsp_valid2, rsp_s2, rsp_z2, rsp_c2, rsp_v2;
  logic [15:0] rsp_dout2;

  int nVec = 0;
  int nMis = 0;

  always #5 clk = ~clk;

  mp_alu #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_use_c(req_use_c), .req_arith(req_arith), .req_cin(req_cin),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dout(rsp_dout), .rsp_s(rsp_s), .rsp_z(rsp_z), .rsp_c(rsp_c), .rsp_v(rsp_v)
  );

  mp_alu #(.WIDTH(16), .SLICE(16)) dutOne (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_op(req_op), .req_use_c(req_use_c), .req_arith(req_arith), .req_cin(req_cin),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2),
    .rsp_dout(rsp_dout2), .rsp_s(rsp_s2), .rsp_z(rsp_z2), .rsp_c(rsp_c2), .rsp_v(rsp_v2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic driveReq(input vec_t v);
    req_op    = v.op;
    req_use_c = v.useC;
    req_arith = v.arith;
    req_cin   = v.cin;
    req_a     = v.a;
    req_b     = v.b;
  endtask

  task automatic scramble();
    req_op    = 3'($urandom);
    req_use_c = 1'($urandom);
    req_arith = 1'($urandom);
    req_cin   = 1'($urandom);
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
  endtask

  // Offers v for one edge on the 4-slice instance, then counts edges until rsp_valid.
  task automatic applyStimulus(input vec_t v, output int lat);
    driveReq(v);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    scramble();
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic releaseRsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  vec_t vecs[19];
  vec_t v;
  int   lat;
  logic seenValid;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //             op    uc    ar    cin   a         b         dout      SZCV
    vecs[0]  = '{ADD,  1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1001};
    vecs[1]  = '{SUB,  1'b0, 1'b0, 1'b1, 16'h0005, 16'h0005, 16'h0000, 4'b0110};
    vecs[2]  = '{SUB,  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'hFFFF, 4'b1000};
    vecs[3]  = '{ADD,  1'b1, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'h0000, 4'b0110};
    vecs[4]  = '{RL,   1'b1, 1'b0, 1'b1, 16'h8000, 16'h0000, 16'h0001, 4'b0010};
    vecs[5]  = '{RR,   1'b0, 1'b1, 1'b0, 16'h8001, 16'h0000, 16'hC000, 4'b1010};
    vecs[6]  = '{RR,   1'b0, 1'b0, 1'b0, 16'h8001, 16'h0000, 16'h4000, 4'b0010};
    vecs[7]  = '{RR,   1'b1, 1'b1, 1'b0, 16'h8001, 16'h0000, 16'h4000, 4'b0010};
    vecs[8]  = '{AND_, 1'b1, 1'b0, 1'b1, 16'h0F0F, 16'h00FF, 16'h000F, 4'b0000};
    vecs[9]  = '{OR_,  1'b0, 1'b0, 1'b0, 16'hF000, 16'h000F, 16'hF00F, 4'b1000};
    vecs[10] = '{XOR_, 1'b0, 1'b0, 1'b0, 16'hAAAA, 16'hAAAA, 16'h0000, 4'b0100};
    vecs[11] = '{NOT_, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h00FF, 16'hFF00, 4'b1000};
    vecs[12] = '{ADD,  1'b0, 1'b0, 1'b0, 16'h8000, 16'h8000, 16'h0000, 4'b0111};
    vecs[13] = '{SUB,  1'b1, 1'b0, 1'b1, 16'h0010, 16'h0001, 16'h000E, 4'b0010};
    vecs[14] = '{ADD,  1'b1, 1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 4'b0000};
    vecs[15] = '{RL,   1'b0, 1'b0, 1'b1, 16'h8000, 16'h0000, 16'h0000, 4'b0110};
    vecs[16] = '{SUB,  1'b0, 1'b0, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'b0011};
    vecs[17] = '{ADD,  1'b0, 1'b0, 1'b1, 16'h0F0F, 16'h00F1, 16'h1000, 4'b0000};
    vecs[18] = '{RR,   1'b1, 1'b0, 1'b1, 16'h0002, 16'h0000, 16'h8001, 4'b1000};

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_outputs", {rsp_dout, rsp_s, rsp_z, rsp_c, rsp_v}, 32'd0);
    checkOutput("reset_one_slice", {req_ready2, rsp_valid2, rsp_dout2, rsp_s2, rsp_z2, rsp_c2, rsp_v2},
                {1'b1, 21'd0});
    rst = 1'b0;
    tick();

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i], lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
      checkOutput($sformatf("vec%0d_result", i), {rsp_dout, rsp_s, rsp_z, rsp_c, rsp_v},
                  {vecs[i].dout, vecs[i].flags});
      releaseRsp();
    end

    // Stalled response with a competing request, then a back-to-back request.
    applyStimulus('{ADD, 1'b0, 1'b0, 1'b0, 16'h1111, 16'h2222, 16'h3333, 4'b0000}, lat);
    checkOutput("bp_first_result", {rsp_dout, rsp_s, rsp_z, rsp_c, rsp_v}, {16'h3333, 4'b0000});
    driveReq('{XOR_, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 4'b0000});
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("bp_stall%0d", i),
                  {rsp_valid, req_ready, rsp_dout, rsp_s, rsp_z, rsp_c, rsp_v},
                  {2'b10, 16'h3333, 4'b0000});
    end
    driveReq('{SUB, 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0005, 16'h0000, 4'b0000});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("bp_after_handshake", {rsp_valid, req_ready}, 32'b01);
    tick();
    req_valid = 1'b0;
    scramble();
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("bp_second_latency", 32'(lat), 32'd5);
    checkOutput("bp_second_result", {rsp_dout, rsp_s, rsp_z, rsp_c, rsp_v}, {16'hFFFE, 4'b1000});
    releaseRsp();

    // Reset two cycles into RUN must abort without a response.
    driveReq('{ADD, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 4'b0000});
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort_state", {req_ready, rsp_valid}, 32'b10);
    checkOutput("abort_outputs", {rsp_dout, rsp_s, rsp_z, rsp_c, rsp_v}, 32'd0);
    seenValid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seenValid = seenValid | rsp_valid;
    end
    checkOutput("abort_no_response", 32'(seenValid), 32'd0);

    // Single-slice build: same ADD, two-cycle latency.
    driveReq('{ADD, 1'b0, 1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h0000, 4'b0000});
    req_valid2 = 1'b1;
    tick();
    req_valid2 = 1'b0;
    scramble();
    lat = 0;
    while (!rsp_valid2 && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("one_slice_latency", 32'(lat), 32'd2);
    checkOutput("one_slice_result", {rsp_dout2, rsp_s2, rsp_z2, rsp_c2, rsp_v2}, {16'h8000, 4'b1001});
    rsp_ready2 = 1'b1;
    tick();
    rsp_ready2 = 1'b0;
    checkOutput("one_slice_release", {rsp_valid2, req_ready2}, 32'b01);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
